// File: rtl/noc_flit_packetizer.sv
// Network-interface packetizer: turns a packet request plus a payload word stream into
// head/body/tail flits through a single registered output stage with valid/ready backpressure.
module noc_flit_packetizer #(
   parameter int FLIT_DATA_W = 32,
   parameter int X_W         = 2,
   parameter int Y_W         = 2,
   parameter int SIZE_W      = 8,
   parameter int N_VC        = 2,
   parameter int CNT_W       = 16,
   localparam int VC_W       = (N_VC > 1) ? $clog2(N_VC) : 1,
   localparam int HD_W       = FLIT_DATA_W - X_W - Y_W - SIZE_W
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [X_W-1:0]           req_x_i,
   input  logic [Y_W-1:0]           req_y_i,
   input  logic [VC_W-1:0]          req_vc_i,
   input  logic [SIZE_W-1:0]        req_size_i,
   input  logic [HD_W-1:0]          req_head_data_i,
   input  logic                     pl_valid_i,
   output logic                     pl_ready_o,
   input  logic [FLIT_DATA_W-1:0]   pl_data_i,
   output logic [FLIT_DATA_W+1:0]   flit_data_o,
   output logic                     valid_o,
   output logic [VC_W-1:0]          vc_id_o,
   input  logic                     ready_i,
   output logic [CNT_W-1:0]         pkt_cnt_o,
   output logic                     dbg_state_o
);

   localparam logic [1:0] T_HEAD      = 2'b00;
   localparam logic [1:0] T_BODY      = 2'b01;
   localparam logic [1:0] T_TAIL      = 2'b10;
   localparam logic [1:0] T_HEAD_TAIL = 2'b11;

   typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

   // Handshake: a word moves when its valid and ready are both high at a rising edge.
   state_t             state;
   logic [SIZE_W-1:0]  rem;
   logic [VC_W-1:0]    vc;
   logic               free;
   logic               req_acc;
   logic               pl_acc;

   assign free        = !valid_o || ready_i;
   assign req_ready_o = arst && (state == IDLE) && free;
   assign pl_ready_o  = arst && (state == BODY) && free;
   assign req_acc     = req_valid_i && req_ready_o;
   assign pl_acc      = pl_valid_i && pl_ready_o;
   assign dbg_state_o = state;

   always_ff @(posedge clk) begin
      if (!arst) begin
         state       <= IDLE;
         rem         <= '0;
         vc          <= '0;
         valid_o     <= 1'b0;
         flit_data_o <= '0;
         vc_id_o     <= '0;
         pkt_cnt_o   <= '0;
      end else begin
         // TAIL and HEAD_TAIL share the upper type bit: both close a packet.
         if (valid_o && ready_i && flit_data_o[FLIT_DATA_W+1])
            pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);

         if (req_acc) begin
            flit_data_o <= {(req_size_i == '0) ? T_HEAD_TAIL : T_HEAD,
                            req_x_i, req_y_i, req_size_i, req_head_data_i};
            vc_id_o     <= req_vc_i;
            vc          <= req_vc_i;
            valid_o     <= 1'b1;
            if (req_size_i != '0) begin
               rem   <= req_size_i;
               state <= BODY;
            end
         end else if (pl_acc) begin
            flit_data_o <= {(rem == SIZE_W'(1)) ? T_TAIL : T_BODY, pl_data_i};
            vc_id_o     <= vc;
            valid_o     <= 1'b1;
            rem         <= rem - SIZE_W'(1);
            if (rem == SIZE_W'(1))
               state <= IDLE;
         end else if (free) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Directed bench for noc_flit_packetizer: drives request/payload/ready, scores every
// transferred flit against an expected queue and tracks the delivered-packet count.
module tb_noc_flit_packetizer;

   localparam int FW   = 32;
   localparam int W    = FW + 2;
   localparam int EW   = W + 1;
   localparam int CW   = 16;

   logic          clk = 1'b0;
   logic          arst;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [1:0]    req_x_i;
   logic [1:0]    req_y_i;
   logic          req_vc_i;
   logic [7:0]    req_size_i;
   logic [19:0]   req_head_data_i;
   logic          pl_valid_i;
   logic          pl_ready_o;
   logic [FW-1:0] pl_data_i;
   logic [W-1:0]  flit_data_o;
   logic          valid_o;
   logic          vc_id_o;
   logic          ready_i;
   logic [CW-1:0] pkt_cnt_o;
   logic          dbg_state_o;

   noc_flit_packetizer #(
      .FLIT_DATA_W(FW), .X_W(2), .Y_W(2), .SIZE_W(8), .N_VC(2), .CNT_W(CW)
   ) dut (
      .clk(clk), .arst(arst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_x_i(req_x_i), .req_y_i(req_y_i), .req_vc_i(req_vc_i),
      .req_size_i(req_size_i), .req_head_data_i(req_head_data_i),
      .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o), .pl_data_i(pl_data_i),
      .flit_data_o(flit_data_o), .valid_o(valid_o), .vc_id_o(vc_id_o),
      .ready_i(ready_i), .pkt_cnt_o(pkt_cnt_o), .dbg_state_o(dbg_state_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard
   logic [EW-1:0] exp_q[$];
   logic [FW-1:0] pl_words [0:255];
   logic [CW-1:0] exp_cnt = '0;
   logic          held_v = 1'b0;
   logic [EW-1:0] held_flit;
   int            cyc = 0;
   int            hs_cnt = 0;
   int            first_cyc = 0;
   int            last_cyc = 0;

   function automatic logic [EW-1:0] head_flit(input logic vc, input logic [1:0] x,
         input logic [1:0] y, input logic [7:0] n, input logic [19:0] hd);
      logic [1:0] t;
      t = (n == 8'd0) ? 2'b11 : 2'b00;
      return {vc, t, x, y, n, hd};
   endfunction

   task automatic expect_pkt(input logic vc, input logic [1:0] x, input logic [1:0] y,
         input logic [7:0] n, input logic [19:0] hd);
      exp_q.push_back(head_flit(vc, x, y, n, hd));
      for (int i = 0; i < int'(n); i++)
         exp_q.push_back({vc, (i == int'(n) - 1) ? 2'b10 : 2'b01, pl_words[i]});
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      cyc++;
      if (!arst) begin
         exp_cnt = '0;
         held_v  = 1'b0;
      end else begin
         check("pkt_cnt", pkt_cnt_o, exp_cnt);
         if (held_v) check("hold_flit", {vc_id_o, flit_data_o}, held_flit);
         held_v = 1'b0;
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_flit", {vc_id_o, flit_data_o}, 64'h0);
            end else begin
               e = exp_q.pop_front();
               check("flit", {vc_id_o, flit_data_o}, e);
               if (e[W-1]) exp_cnt = exp_cnt + 1'b1;
            end
            if (hs_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            hs_cnt++;
         end else if (valid_o) begin
            held_v    = 1'b1;
            held_flit = {vc_id_o, flit_data_o};
         end
      end
   end

   // drivers
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive_req(input logic [1:0] x, input logic [1:0] y, input logic vc,
         input logic [7:0] n, input logic [19:0] hd);
      int t;
      logic ok;
      req_valid_i = 1'b1; req_x_i = x; req_y_i = y; req_vc_i = vc;
      req_size_i = n; req_head_data_i = hd;
      t = 0;
      do begin
         @(negedge clk); ok = req_ready_o; t++;
      end while (!ok && t < 400);
      if (!ok) check("req_timeout", 64'd0, 64'd1);
      step();
      req_valid_i = 1'b0;
   endtask

   task automatic drive_pl(input int n, input int gap_at, input int gap_len);
      int t;
      logic ok;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            pl_valid_i = 1'b0;
            for (int j = 0; j < gap_len; j++) begin
               @(negedge clk);
               check("starve_req_ready", req_ready_o, 64'd0);
               if (j == gap_len - 1) check("starve_valid", valid_o, 64'd0);
               step();
            end
         end
         pl_valid_i = 1'b1; pl_data_i = pl_words[i];
         t = 0;
         do begin
            @(negedge clk); ok = pl_ready_o; t++;
         end while (!ok && t < 400);
         if (!ok) check("pl_timeout", 64'd0, 64'd1);
         step();
      end
      pl_valid_i = 1'b0;
   endtask

   task automatic drive_ready(input logic [7:0] pat, input int len);
      for (int i = len - 1; i >= 0; i--) begin
         ready_i = pat[i];
         step();
      end
      ready_i = 1'b1;
   endtask

   task automatic settle();
      repeat (4) step();
      check("drained", exp_q.size(), 64'd0);
   endtask

   task automatic do_reset();
      arst = 1'b0;
      repeat (2) step();
      arst = 1'b1;
   endtask

   // stimulus
   initial begin
      arst = 1'b0; req_valid_i = 1'b1; req_x_i = '0; req_y_i = '0; req_vc_i = 1'b0;
      req_size_i = '0; req_head_data_i = '0; pl_valid_i = 1'b1; pl_data_i = '0;
      ready_i = 1'b1;
      repeat (3) step();
      @(negedge clk);
      check("rst_valid", valid_o, 64'd0);
      check("rst_flit", flit_data_o, 64'd0);
      check("rst_vc", vc_id_o, 64'd0);
      check("rst_cnt", pkt_cnt_o, 64'd0);
      check("rst_req_ready", req_ready_o, 64'd0);
      check("rst_pl_ready", pl_ready_o, 64'd0);
      check("rst_state", dbg_state_o, 64'd0);
      step();
      req_valid_i = 1'b0; pl_valid_i = 1'b0; arst = 1'b1;
      @(negedge clk);
      check("idle_req_ready", req_ready_o, 64'd1);
      check("idle_pl_ready", pl_ready_o, 64'd0);
      step();

      // head-only packet, flit constant computed by hand
      exp_q.push_back({1'b0, 34'h3_3000_CAFE});
      drive_req(2'd0, 2'd3, 1'b0, 8'd0, 20'h0CAFE);
      @(negedge clk);
      check("ht_cnt_before", pkt_cnt_o, 64'd0);
      step();
      check("ht_cnt_after", pkt_cnt_o, 64'd1);
      settle();

      // 4-payload packet, continuous flow
      pl_words[0] = 32'h11; pl_words[1] = 32'h22; pl_words[2] = 32'h33; pl_words[3] = 32'h44;
      expect_pkt(1'b1, 2'd1, 2'd2, 8'd4, 20'h12345);
      hs_cnt = 0;
      fork
         drive_req(2'd1, 2'd2, 1'b1, 8'd4, 20'h12345);
         drive_pl(4, -1, 0);
      join
      settle();
      check("p4_flits", hs_cnt, 64'd5);
      check("p4_span", last_cyc - first_cyc, 64'd4);

      // backpressure on a 3-payload packet
      pl_words[0] = 32'hB1; pl_words[1] = 32'hB2; pl_words[2] = 32'hB3;
      expect_pkt(1'b0, 2'd2, 2'd1, 8'd3, 20'hABCDE);
      hs_cnt = 0;
      fork
         drive_req(2'd2, 2'd1, 1'b0, 8'd3, 20'hABCDE);
         drive_pl(3, -1, 0);
         drive_ready(8'b1001_1010, 8);
      join
      settle();
      check("bp_flits", hs_cnt, 64'd4);

      // payload starvation mid-packet
      pl_words[0] = 32'hA1; pl_words[1] = 32'hA2; pl_words[2] = 32'hA3;
      expect_pkt(1'b1, 2'd3, 2'd0, 8'd3, 20'h00001);
      hs_cnt = 0;
      fork
         drive_req(2'd3, 2'd0, 1'b1, 8'd3, 20'h00001);
         drive_pl(3, 1, 3);
      join
      settle();
      check("starve_flits", hs_cnt, 64'd4);

      // back-to-back N=2 then N=0 from a clean counter
      do_reset();
      pl_words[0] = 32'hC1; pl_words[1] = 32'hC2;
      expect_pkt(1'b0, 2'd1, 2'd1, 8'd2, 20'h00C00);
      expect_pkt(1'b1, 2'd2, 2'd2, 8'd0, 20'h00D00);
      hs_cnt = 0;
      fork
         begin
            drive_req(2'd1, 2'd1, 1'b0, 8'd2, 20'h00C00);
            drive_req(2'd2, 2'd2, 1'b1, 8'd0, 20'h00D00);
         end
         drive_pl(2, -1, 0);
      join
      settle();
      check("b2b_span", last_cyc - first_cyc, 64'd3);
      check("b2b_cnt", pkt_cnt_o, 64'd2);

      // largest packet: N=255 -> 1 head, 254 body, 1 tail
      for (int i = 0; i < 256; i++) pl_words[i] = 32'h1000 + i;
      expect_pkt(1'b1, 2'd0, 2'd0, 8'd255, 20'hFFFFF);
      hs_cnt = 0;
      fork
         drive_req(2'd0, 2'd0, 1'b1, 8'd255, 20'hFFFFF);
         drive_pl(255, -1, 0);
      join
      settle();
      check("max_flits", hs_cnt, 64'd256);
      check("max_span", last_cyc - first_cyc, 64'd255);
      check("max_cnt", pkt_cnt_o, 64'd3);

      // reset after the 2nd of 4 payloads; body flit 0x52 is in flight and discarded
      pl_words[0] = 32'h51; pl_words[1] = 32'h52;
      exp_q.push_back(head_flit(1'b1, 2'd1, 2'd3, 8'd4, 20'h00055));
      exp_q.push_back({1'b1, 2'b01, 32'h51});
      fork
         drive_req(2'd1, 2'd3, 1'b1, 8'd4, 20'h00055);
         drive_pl(2, -1, 0);
      join
      ready_i = 1'b0; arst = 1'b0;
      step();
      arst = 1'b1; ready_i = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", valid_o, 64'd0);
      check("mid_rst_cnt", pkt_cnt_o, 64'd0);
      check("mid_rst_state", dbg_state_o, 64'd0);
      check("mid_rst_req_ready", req_ready_o, 64'd1);
      check("mid_rst_q", exp_q.size(), 64'd0);
      step();
      pl_words[0] = 32'h77;
      expect_pkt(1'b0, 2'd2, 2'd3, 8'd1, 20'h00066);
      fork
         drive_req(2'd2, 2'd3, 1'b0, 8'd1, 20'h00066);
         drive_pl(1, -1, 0);
      join
      settle();
      check("post_rst_cnt", pkt_cnt_o, 64'd1);

      // final report
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/noc_flit_packetizer.md
# noc_flit_packetizer

Network-interface packetizer that sits directly upstream of the NoC router input (`flit_data_i` / `valid_i` / `vc_id_i` / `ready_o`). It accepts a packet request (destination, VC, size, head data) plus a stream of payload words, and emits a well-formed head/body/tail flit sequence with valid/ready backpressure. It is a fully registered output stage with one-flit-per-cycle throughput and no bubbles between back-to-back packets.

## Interface
Parameters:
- `FLIT_DATA_W`, 32: payload bits per flit; flit width is `FLIT_DATA_W+2`.
- `X_W`, 2: x_dest field width.
- `Y_W`, 2: y_dest field width.
- `SIZE_W`, 8: pkt_size field width (payload flits after the head).
- `N_VC`, 2: number of virtual channels; `VC_W = $clog2(N_VC)`.
- `CNT_W`, 16: sent-packet counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `arst` in 1: reset, synchronous, active-low.
- `req_valid_i` in 1: packet request valid.
- `req_ready_o` out 1: packet request accepted when high with `req_valid_i`.
- `req_x_i` in X_W: destination x.
- `req_y_i` in Y_W: destination y.
- `req_vc_i` in VC_W: virtual channel for the whole packet.
- `req_size_i` in SIZE_W: payload flit count N (0 = head-only packet).
- `req_head_data_i` in FLIT_DATA_W-X_W-Y_W-SIZE_W: data carried in the head flit.
- `pl_valid_i` in 1: payload word valid.
- `pl_ready_o` out 1: payload word accepted when high with `pl_valid_i`.
- `pl_data_i` in FLIT_DATA_W: payload word.
- `flit_data_o` out FLIT_DATA_W+2: flit to router.
- `valid_o` out 1: flit valid.
- `vc_id_o` out VC_W: flit VC.
- `ready_i` in 1: router ready.
- `pkt_cnt_o` out CNT_W: packets fully delivered.

## Operation
- Flit format: `[W+1:W]` type: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet). Head payload, MSB first: x_dest, y_dest, pkt_size, head_data. Body/tail payload: `pl_data_i` verbatim.
- Output register (`flit_data_o`, `vc_id_o`, `valid_o`) is free when `!valid_o || ready_i`.
- FSM states IDLE, BODY; remaining counter `rem` (SIZE_W bits); latched `vc`.
- IDLE: `req_ready_o = free`; `pl_ready_o = 0`. On request accept: load head flit and `req_vc_i`, set `valid_o`. If N==0, type HEAD_TAIL, stay IDLE; else type HEAD, `rem = N`, go BODY.
- BODY: `req_ready_o = 0`; `pl_ready_o = free`. On payload accept: load word with latched vc, `rem--`. Type TAIL when `rem==1` (then go IDLE), otherwise BODY.
- If free and nothing is loaded, `valid_o` clears.
- Once `valid_o` is high, `flit_data_o` and `vc_id_o` stay stable until `ready_i`.
- `pkt_cnt_o` increments on `valid_o && ready_i` with type TAIL or HEAD_TAIL. It wraps modulo 2^CNT_W.
- N = 2^SIZE_W-1 is legal and produces 1 head, N-1 body and 1 tail flit.

## Timing
- While `arst` is low at a clock edge: state IDLE, `rem = 0`, `vc = 0`, `valid_o = 0`, `flit_data_o = 0`, `vc_id_o = 0`, `pkt_cnt_o = 0`. `req_ready_o` and `pl_ready_o` are forced 0 while `arst` is low.
- Reset mid-packet discards the in-flight flit and remaining payload count. No partial tail is emitted.
- Request accepted at edge k: head flit is valid from k to k+1.
- Payload accepted at edge k: its flit is valid from k to k+1.
- Ready paths are combinational from `ready_i`; the data/valid outputs are registered.
- With continuous `ready_i`/`pl_valid_i`/`req_valid_i`, an N-payload packet occupies N+1 consecutive cycles. The next head follows the tail on the very next cycle.
- With `ready_i` low, the held flit persists and no new request or payload is accepted.

## Test plan
- Head-only packet: x=0, y=3, N=0, head_data=0xCAFE, `ready_i`=1 -> one HEAD_TAIL flit with fields matching; `pkt_cnt_o` goes 0→1 one cycle after the handshake.
- 4-payload packet: vc=1, payload 0x11..0x44 -> HEAD, BODY 0x11/0x22/0x33, TAIL 0x44 on 5 consecutive cycles, all with `vc_id_o`=1.
- Backpressure: `ready_i` toggling 1,0,0,1 during a 3-payload packet -> each flit is held stable while low, no flit is dropped or duplicated, order is preserved.
- Payload starvation: `pl_valid_i` low for 3 cycles mid-packet -> `valid_o` drops after the drain, then resumes. `req_ready_o` stays 0 throughout BODY.
- Back-to-back: packets N=2 then N=0 -> TAIL immediately followed by HEAD_TAIL with no idle cycle; `pkt_cnt_o`=2.
- Reset mid-packet: `arst` low for 1 cycle after the 2nd of 4 payloads -> `valid_o`=0 and `pkt_cnt_o`=0. The next request starts cleanly with a HEAD flit.
